elevator_scheduler: RTL

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elev_pkg.sv | 29 ++
 rtl/elev_request_eval.sv | 35 +++
 rtl/elevator_scheduler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/elev_pkg.sv
// elev_pkg: shared FSM states, floor type, hall-call bit positions and the
// nearest-request helper used by the elevator scheduler.
package elev_pkg;
    localparam int NUM_FLOORS = 4;
    localparam int HALL_DN_F1 = 0;
    localparam int HALL_DN_F2 = 1;
    localparam int HALL_DN_F3 = 2;
    localparam int HALL_UP_F0 = 3;
    localparam int HALL_UP_F1 = 4;
    localparam int HALL_UP_F2 = 5;
    typedef logic [1:0] floor_t;
    typedef enum logic [1:0] {IDLE, MOVE, DOOR, CLOSE} state_t;
    // 1 when the closest requested floor lies above f; the lower floor wins a tie
    function automatic logic nearest_up(input logic [NUM_FLOORS-1:0] m, input floor_t f);
        logic found;
        logic up;
        found = 1'b0;
        up = 1'b0;
        for (int d = 1; d < NUM_FLOORS; d++) begin
            if (!found && int'(f) >= d && m[f - floor_t'(d)]) begin
                found = 1'b1;
            end else if (!found && int'(f) + d < NUM_FLOORS && m[f + floor_t'(d)]) begin
                found = 1'b1;
                up = 1'b1;
            end
        end
        return up;
    endfunction
endpackage

// File: rtl/elev_request_eval.sv
// elev_request_eval: combinational summary of outstanding requests as seen
// from one floor and sweep direction.
module elev_request_eval
    import elev_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pend,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_dn,
    input  floor_t                at_floor,
    input  logic                  dir_up,
    output logic                  stop_here,
    output logic                  flip_here,
    output logic                  req_here,
    output logic                  req_above,
    output logic                  req_below
);
    logic [NUM_FLOORS-1:0] mask;
    logic [NUM_FLOORS-1:0] above_m;
    logic [NUM_FLOORS-1:0] below_m;
    logic opp;
    logic beyond;
    always_comb begin
        mask      = pend | hall_up | hall_dn;
        above_m   = 4'b1110 << at_floor;
        below_m   = (4'b0001 << at_floor) - 4'b0001;
        req_here  = mask[at_floor];
        req_above = |(mask & above_m);
        req_below = |(mask & below_m);
        beyond    = dir_up ? req_above : req_below;
        opp       = dir_up ? hall_dn[at_floor] : hall_up[at_floor];
        // an opposite hall call is only served once nothing lies further along the sweep
        flip_here = opp & ~beyond;
        stop_here = pend[at_floor] | (dir_up ? hall_up[at_floor] : hall_dn[at_floor]) | flip_here;
    end
endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: single-car, four-floor sweep scheduler (IDLE/MOVE/DOOR/CLOSE).
// Defining ELEV_DOOR_HOLD_EN adds a door_hold input that freezes the door timer.
module elevator_scheduler
    import elev_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            request_out_seq,
    input  logic [NUM_FLOORS-1:0] request_in,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output floor_t                current_floor,
    output logic                  opnd,
    output logic                  dir_up,
    output logic                  moving,
    output logic [NUM_FLOORS-1:0] cabin_pending
);
    localparam int TW = $clog2(TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES);
    localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES - 1);

    state_t state, state_n;
    floor_t floor_n, nxt_floor;
    logic dir_n, hold, restart, unused_eval;
    logic [TW-1:0] timer, timer_n;
    logic [NUM_FLOORS-1:0] pend, hall_up, hall_dn, cabin_n;
    logic cur_stop, cur_flip, cur_here, cur_above, cur_below;
    logic nxt_stop, nxt_flip, nxt_here, nxt_above, nxt_below;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif
    assign pend    = cabin_pending | request_in;
    assign hall_up = {1'b0, request_out_seq[HALL_UP_F2], request_out_seq[HALL_UP_F1], request_out_seq[HALL_UP_F0]};
    assign hall_dn = {request_out_seq[HALL_DN_F3], request_out_seq[HALL_DN_F2], request_out_seq[HALL_DN_F1], 1'b0};
    assign nxt_floor = dir_up ? (current_floor == 2'd3 ? 2'd3 : current_floor + 2'd1)
                              : (current_floor == 2'd0 ? 2'd0 : current_floor - 2'd1);
    assign restart = request_in[current_floor] | (dir_up ? hall_up[current_floor] : hall_dn[current_floor]);
    assign unused_eval = cur_stop & nxt_here;

    // u_cur judges the floor the car is at, u_nxt the floor it is about to reach
    elev_request_eval u_cur (
        .pend(pend), .hall_up(hall_up), .hall_dn(hall_dn), .at_floor(current_floor), .dir_up(dir_up),
        .stop_here(cur_stop), .flip_here(cur_flip), .req_here(cur_here), .req_above(cur_above), .req_below(cur_below)
    );
    elev_request_eval u_nxt (
        .pend(pend), .hall_up(hall_up), .hall_dn(hall_dn), .at_floor(nxt_floor), .dir_up(dir_up),
        .stop_here(nxt_stop), .flip_here(nxt_flip), .req_here(nxt_here), .req_above(nxt_above), .req_below(nxt_below)
    );

    always_comb begin
        state_n = state;
        floor_n = current_floor;
        dir_n   = dir_up;
        timer_n = timer;
        case (state)
            IDLE: begin
                if (cur_here) begin
                    state_n = DOOR;
                    timer_n = DOOR_LD;
                    dir_n   = dir_up ^ cur_flip;
                end else if (cur_above | cur_below) begin
                    state_n = MOVE;
                    timer_n = TRAVEL_LD;
                    dir_n   = nearest_up(pend | hall_up | hall_dn, current_floor);
                end
            end
            MOVE: begin
                timer_n = (timer != '0) ? timer - TW'(1) : TRAVEL_LD;
                if (timer == '0) begin
                    floor_n = nxt_floor;
                    if (nxt_stop) begin
                        state_n = DOOR;
                        timer_n = DOOR_LD;
                        dir_n   = dir_up ^ nxt_flip;
                    end else if (!(dir_up ? nxt_above : nxt_below)) begin
                        state_n = (nxt_above | nxt_below) ? MOVE : IDLE;
                        dir_n   = dir_up ^ (nxt_above | nxt_below);
                    end
                end
            end
            DOOR: begin
                timer_n = restart ? DOOR_LD : (hold || timer == '0) ? timer : timer - TW'(1);
                state_n = (!restart && !hold && timer == '0) ? CLOSE : DOOR;
            end
            CLOSE: begin
                state_n = (cur_above | cur_below) ? MOVE : IDLE;
                timer_n = TRAVEL_LD;
                dir_n   = dir_up ^ (!(dir_up ? cur_above : cur_below) && (cur_above | cur_below));
            end
        endcase
        dir_n   = (floor_n == 2'd3) ? 1'b0 : (floor_n == 2'd0) ? 1'b1 : dir_n;
        cabin_n = (cabin_pending | request_in) & ~((state_n == DOOR) ? (4'b0001 << floor_n) : 4'b0000);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            current_floor <= '0;
            dir_up        <= 1'b1;
            opnd          <= 1'b0;
            moving        <= 1'b0;
            cabin_pending <= '0;
            timer         <= '0;
        end else begin
            state         <= state_n;
            current_floor <= floor_n;
            dir_up        <= dir_n;
            opnd          <= (state_n == DOOR);
            moving        <= (state_n == MOVE);
            cabin_pending <= cabin_n;
            timer         <= timer_n;
        end
    end
endmodule
